im_bundle_fetch: RTL and testbench

//  Reader side of the instruction memory. Drives the 4-bit bundle select into the IM.

---
 rtl/im_bundle_fetch.sv | 127 ++++++++++++
 tb/tb_im_bundle_fetch.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/im_bundle_fetch.sv
// Instruction-memory reader: walks the bundle index and registers each 48-bit bundle
// for decode behind a valid/ready handshake, with redirect, wrap and halt-on-empty.
module im_bundle_fetch #(
  parameter int          IDX_W        = 4,
  parameter int unsigned LAST_IDX     = 15,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [IDX_W-1:0] im_sel,
  input  logic [47:0]      im_bundle,
  input  logic             redirect_valid,
  input  logic [IDX_W-1:0] redirect_idx,
  output logic             bundle_valid,
  input  logic             bundle_ready,
  output logic [IDX_W-1:0] bundle_idx,
  output logic [31:0]      slot32,
  output logic [15:0]      slot16,
  output logic             slot32_ok,
  output logic             slot16_ok,
  output logic             halted
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StHalt = 2'd2;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(LAST_IDX);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [31:0]      s32_q, s32_d;
  logic [15:0]      s16_q, s16_d;
  logic             ok32_q, ok32_d;
  logic             ok16_q, ok16_d;
  logic             halted_q, halted_d;

  logic load;
  logic empty;

  assign load  = !valid_q || bundle_ready;
  assign empty = HALT_ON_ZERO && (im_bundle == 48'h0);

  // Redirect outranks both loading and empty-bundle detection, and revives a halted fetch.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    s32_d    = s32_q;
    s16_d    = s16_q;
    ok32_d   = ok32_q;
    ok16_d   = ok16_q;
    halted_d = halted_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          sel_d   = '0;
        end
      end
      StRun, StHalt: begin
        if (redirect_valid) begin
          state_d  = StRun;
          sel_d    = redirect_idx;
          valid_d  = 1'b0;
          ok32_d   = 1'b0;
          ok16_d   = 1'b0;
          halted_d = 1'b0;
        end else if (state_q == StRun && load) begin
          if (empty) begin
            state_d  = StHalt;
            valid_d  = 1'b0;
            ok32_d   = 1'b0;
            ok16_d   = 1'b0;
            halted_d = 1'b1;
          end else begin
            valid_d = 1'b1;
            idx_d   = sel_q;
            s32_d   = im_bundle[47:16];
            s16_d   = im_bundle[15:0];
            ok32_d  = (im_bundle[17:16] == 2'b11);
            ok16_d  = (im_bundle[1:0] != 2'b11) && (im_bundle[15:0] != 16'h0000);
            sel_d   = (sel_q == LastIdx) ? '0 : sel_q + IDX_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      sel_q    <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      s32_q    <= '0;
      s16_q    <= '0;
      ok32_q   <= 1'b0;
      ok16_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      s32_q    <= s32_d;
      s16_q    <= s16_d;
      ok32_q   <= ok32_d;
      ok16_q   <= ok16_d;
      halted_q <= halted_d;
    end
  end

  assign im_sel       = sel_q;
  assign bundle_valid = valid_q;
  assign bundle_idx   = idx_q;
  assign slot32       = s32_q;
  assign slot16       = s16_q;
  assign slot32_ok    = ok32_q;
  assign slot16_ok    = ok16_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_im_bundle_fetch.sv
// Bench for im_bundle_fetch: directed vector table, random traffic against a
// bundle-stream model, and a wrap run on a second instance that delivers empty bundles.
module tb_im_bundle_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, redirect_valid, bundle_ready;
  logic [3:0]  redirect_idx, im_sel, bundle_idx;
  logic [47:0] im_bundle;
  logic        bundle_valid, slot32_ok, slot16_ok, halted;
  logic [31:0] slot32;
  logic [15:0] slot16;
  logic [47:0] mem [16];

  logic        start2, ready2;
  logic [3:0]  imSel2, bundleIdx2;
  logic [47:0] imBundle2;
  logic        valid2, ok32b, ok16b, halted2;
  logic [31:0] slot32b;
  logic [15:0] slot16b;
  logic [47:0] mem2 [16];

  assign im_bundle = mem[im_sel];
  assign imBundle2 = mem2[imSel2];

  im_bundle_fetch #(.IDX_W(4), .LAST_IDX(15), .HALT_ON_ZERO(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .im_sel(im_sel), .im_bundle(im_bundle),
    .redirect_valid(redirect_valid), .redirect_idx(redirect_idx),
    .bundle_valid(bundle_valid), .bundle_ready(bundle_ready), .bundle_idx(bundle_idx),
    .slot32(slot32), .slot16(slot16), .slot32_ok(slot32_ok), .slot16_ok(slot16_ok),
    .halted(halted)
  );

  im_bundle_fetch #(.IDX_W(4), .LAST_IDX(15), .HALT_ON_ZERO(1'b0)) dutNoHalt (
    .clk(clk), .reset(reset), .start(start2), .im_sel(imSel2), .im_bundle(imBundle2),
    .redirect_valid(1'b0), .redirect_idx(4'd0),
    .bundle_valid(valid2), .bundle_ready(ready2), .bundle_idx(bundleIdx2),
    .slot32(slot32b), .slot16(slot16b), .slot32_ok(ok32b), .slot16_ok(ok16b),
    .halted(halted2)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       st, rdy, rv;
    logic [3:0] ridx;
    logic       ev;
    logic [3:0] eidx, esel;
    logic       eh;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic st, logic rdy, logic rv, logic [3:0] ridx,
                              logic ev, logic [3:0] eidx, logic [3:0] esel, logic eh);
    vec_t v;
    v.st = st; v.rdy = rdy; v.rv = rv; v.ridx = ridx;
    v.ev = ev; v.eidx = eidx; v.esel = esel; v.eh = eh;
    return v;
  endfunction

  function automatic logic legal32(logic [47:0] b);
    return b[17:16] == 2'b11;
  endfunction

  function automatic logic legal16(logic [47:0] b);
    return (b[1:0] != 2'b11) && (b[15:0] != 16'h0000);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic rdy, input logic rv, input logic [3:0] ridx);
    start = st;
    bundle_ready = rdy;
    redirect_valid = rv;
    redirect_idx = ridx;
    tick();
  endtask

  // Presented bundle must be exactly mem[idx]; legality flags must drop with valid.
  task automatic checkBundle(input string tag, input logic ev, input logic [3:0] eidx);
    checkOutput({tag, " valid"}, 64'(bundle_valid), 64'(ev));
    if (ev) begin
      checkOutput({tag, " idx"}, 64'(bundle_idx), 64'(eidx));
      checkOutput({tag, " slot32"}, 64'(slot32), 64'(mem[eidx][47:16]));
      checkOutput({tag, " slot16"}, 64'(slot16), 64'(mem[eidx][15:0]));
      checkOutput({tag, " ok32"}, 64'(slot32_ok), 64'(legal32(mem[eidx])));
      checkOutput({tag, " ok16"}, 64'(slot16_ok), 64'(legal16(mem[eidx])));
    end else begin
      checkOutput({tag, " ok32"}, 64'(slot32_ok), 64'(0));
      checkOutput({tag, " ok16"}, 64'(slot16_ok), 64'(0));
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " valid"}, 64'(bundle_valid), 64'(0));
    checkOutput({tag, " sel"}, 64'(im_sel), 64'(0));
    checkOutput({tag, " idx"}, 64'(bundle_idx), 64'(0));
    checkOutput({tag, " slots"}, {16'h0, slot32, slot16}, 64'(0));
    checkOutput({tag, " oks"}, 64'({slot32_ok, slot16_ok}), 64'(0));
    checkOutput({tag, " halted"}, 64'(halted), 64'(0));
  endtask

  logic       mValid, mHalted;
  logic [3:0] mIdx, mNext;

  initial begin
    reset = 1'b1; start2 = 1'b0; ready2 = 1'b0;
    start = 1'b0; bundle_ready = 1'b0; redirect_valid = 1'b0; redirect_idx = '0;
    mem[0] = {32'h002080B3, 16'h8296};
    mem[1] = {32'h40115213, 16'h5B15};
    mem[2] = {32'h00000010, 16'h0003};
    for (int i = 3; i < 16; i++)
      mem[i] = {32'h00510000 + 32'(i << 8) + 32'(i % 4), 16'h4000 + 16'(i << 4) + 16'((i + 1) % 4)};
    mem[6] = 48'h0;
    for (int i = 0; i < 16; i++)
      mem2[i] = {32'h00000013 + 32'(i << 7), 16'h0001 + 16'(i << 2)};
    mem2[6] = 48'h0;

    // Reset held two cycles with start pulsing must leave the block idle.
    for (int i = 0; i < 2; i++) begin
      start = 1'b1;
      tick();
      checkResetState("reset");
    end
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
    checkResetState("idle after reset");

    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 2, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 2, 3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 3, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 3, 4, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 4, 5, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 5, 6, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 6, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 6, 1));
    vecs.push_back(mk(0, 1, 1, 4, 0, 0, 4, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 4, 5, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 5, 6, 0));
    vecs.push_back(mk(0, 1, 1, 9, 0, 0, 9, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 9, 10, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 10, 11, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 10, 11, 0));
    vecs.push_back(mk(0, 0, 1, 3, 0, 0, 3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 3, 4, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 3, 4, 0));

    foreach (vecs[n]) begin
      applyStimulus(vecs[n].st, vecs[n].rdy, vecs[n].rv, vecs[n].ridx);
      checkBundle($sformatf("vec%0d", n), vecs[n].ev, vecs[n].eidx);
      checkOutput($sformatf("vec%0d sel", n), 64'(im_sel), 64'(vecs[n].esel));
      checkOutput($sformatf("vec%0d halted", n), 64'(halted), 64'(vecs[n].eh));
    end

    // A bundle still in flight must vanish on reset.
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0);
    checkResetState("mid reset");
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      mem[i] = {$urandom, 16'($urandom)};
      if ($urandom_range(0, 7) == 0) mem[i] = 48'h0;
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
    checkOutput("rand start valid", 64'(bundle_valid), 64'(0));
    mValid = 1'b0; mHalted = 1'b0; mIdx = '0; mNext = '0;

    // Model: bundles stream out in index order; stalls freeze, redirects restart, empties stop.
    for (int c = 0; c < 400; c++) begin
      logic st, rdy, rv;
      logic [3:0] ridx;
      st = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      rv = ($urandom_range(0, 7) == 0);
      ridx = 4'($urandom_range(0, 15));
      applyStimulus(st, rdy, rv, ridx);
      if (rv) begin
        mValid = 1'b0; mHalted = 1'b0; mNext = ridx;
      end else if (!mHalted && !(mValid && !rdy)) begin
        if (mem[mNext] == 48'h0) begin
          mValid = 1'b0; mHalted = 1'b1;
        end else begin
          mValid = 1'b1; mIdx = mNext; mNext = 4'((int'(mNext) + 1) % 16);
        end
      end
      checkBundle($sformatf("rand%0d", c), mValid, mIdx);
      checkOutput($sformatf("rand%0d halted", c), 64'(halted), 64'(mHalted));
      checkOutput($sformatf("rand%0d sel", c), 64'(im_sel), 64'(mNext));
    end

    // Wrap run: empty bundles are ordinary data and the index stream has no gaps.
    start2 = 1'b1; ready2 = 1'b1;
    tick();
    start2 = 1'b0;
    checkOutput("wrap start valid", 64'(valid2), 64'(0));
    for (int k = 0; k < 36; k++) begin
      tick();
      checkOutput($sformatf("wrap%0d valid", k), 64'(valid2), 64'(1));
      checkOutput($sformatf("wrap%0d idx", k), 64'(bundleIdx2), 64'(k % 16));
      checkOutput($sformatf("wrap%0d slots", k), 64'({slot32b, slot16b}), 64'(mem2[k % 16]));
      checkOutput($sformatf("wrap%0d oks", k), 64'({ok32b, ok16b}),
                  64'({legal32(mem2[k % 16]), legal16(mem2[k % 16])}));
      checkOutput($sformatf("wrap%0d halted", k), 64'(halted2), 64'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
